regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file; successor to the single-port byte register file.
//  Clocked write, registered reads, optional write-to-read bypass, byte-lane write enables.
//  Hardware clear sequencer instead of a per-entry reset; sticky out-of-range address error.
//  Sits beside the datapath as the general-purpose operand store.
// PARAMETERS
//  DATA_W   8   bits per entry; must be a multiple of 8
//  DEPTH    4   number of entries, >=2; need not be a power of 2
//  N_RD     2   number of independent read ports, >=1
//  AW       8   address width in bits; AW >= $clog2(DEPTH)
//  BYPASS   1   1: a same-cycle write to a read address is forwarded; 0: old data is returned
// PORTS
//  clk       in   1             single clock; all state changes on its rising edge
//  rst       in   1             asynchronous, active-high reset
//  clear     in   1             1-cycle pulse; restarts the clear sequence (ignored while busy)
//  rd_en     in   N_RD          per-port read request
//  rd_addr   in   N_RD*AW       packed read addresses; port p uses [p*AW +: AW]
//  rd_data   out  N_RD*DATA_W   packed read data, registered
//  rd_valid  out  N_RD          per-port: rd_data is valid this cycle
//  wr_en     in   1             write request
//  wr_addr   in   AW            write address
//  wr_be     in   DATA_W/8      byte-lane enables; bit b gates wr_data[8b +: 8]
//  wr_data   in   DATA_W        write data
//  busy      out  1             clear sequence running; all requests are ignored
//  addr_err  out  1             sticky flag: an out-of-range access was accepted
//  err_clr   in   1             clears addr_err
// BEHAVIOUR
//  FSM states: INIT (clearing) and READY.
//  Reset (async, rst=1):
//   - state=INIT, clr_ptr=0, busy=1
//   - rd_data=0, rd_valid=0, addr_err=0
//   - array contents are not reset directly
//  INIT:
//   - each cycle, write 0 to entry clr_ptr, then clr_ptr++
//   - after entry DEPTH-1 is written, go to READY and drive busy=0
//   - so busy is high for exactly DEPTH cycles after rst is released
//   - rd_en and wr_en are ignored: no array write, rd_valid=0, no addr_err
//  READY:
//   - clear=1 -> INIT with clr_ptr=0; busy=1 from the next cycle
//   - a write also presented in that same cycle still completes
//  Write (READY only):
//   - wr_en=1 with wr_addr<DEPTH: each lane with wr_be[b]=1 is updated at the edge
//   - wr_be=0 is a legal no-op
//  Read (READY only):
//   - rd_en[p] in cycle N -> rd_valid[p]=1 and rd_data[p]=entry in cycle N+1 (latency 1)
//   - rd_en[p]=0 -> in cycle N+1, rd_valid[p]=0 and rd_data[p]=0
//   - read ports are fully independent; any ports may share an address
//  Read/write collision (same address, same cycle):
//   - BYPASS=1: returned data is the merge; enabled lanes come from wr_data, others from the old entry
//   - BYPASS=0: returned data is the pre-write entry
//  Out of range (addr >= DEPTH):
//   - the write is dropped
//   - the read returns rd_valid=1 with rd_data=0
//   - either case sets addr_err at the next edge
//   - addr_err holds until err_clr=1 or rst
//   - if err_clr=1 and a new error occur in the same cycle, the set wins
//  Reset mid-operation (mid-clear or mid-read): outputs take reset values immediately; the sequence restarts.
// STRUCTURE
//  Shared package regfile_pkg:
//   - state enum {INIT, READY}
//   - function lane_merge(old, new, be) returning a DATA_W-bit value
//  Sub-module regfile_rdport (one instance per read port, generate loop):
//   - address range check
//   - bypass compare and merge
//   - output register
//  Top level holds the array, the write logic, the FSM/clear pointer and the error flag.
// TESTING
//  1. Release rst with DEPTH=4 -> busy=1 for 4 cycles, then 0; every read returns rd_valid=1, data 0x00.
//  2. Write 0xA5 to addr 2, then read addr 2 on both ports next cycle -> both rd_data=0xA5, rd_valid=1 one cycle later.
//  3. Entry 1 holds 0x3C; write 0xF0 to addr 1 while port 0 reads addr 1 -> BYPASS=1: 0xF0; BYPASS=0: 0x3C.
//  4. DATA_W=16: entry holds 0x1234; write 0xABCD with wr_be=2'b10 -> readback 0xAB34.
//  5. DEPTH=3: read addr 3 -> rd_valid=1, rd_data=0, addr_err=1; write addr 3 -> array unchanged.
//     err_clr=1 -> addr_err=0.
//  6. Pulse clear, and separately assert rst two cycles into the clear sequence:
//     - busy restarts for a full DEPTH cycles
//     - all entries read 0 afterwards
//     - wr_en during busy has no effect

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and helpers for the multi-read-port register
//               file: FSM state encoding and the byte-lane merge function.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Widest entry the lane-merge helper can handle; callers zero-extend
    // their DATA_W operands to this width and truncate the result back.
    localparam int c_MAX_W  = 256;
    localparam int c_MAX_BE = c_MAX_W / 8;

    // Clear sequencer states.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Lanes with be[b]=1 take new_val, all others keep old_val.
    function automatic logic [c_MAX_W-1:0] lane_merge(
        input logic [c_MAX_W-1:0]  old_val,
        input logic [c_MAX_W-1:0]  new_val,
        input logic [c_MAX_BE-1:0] be
    );
        logic [c_MAX_W-1:0] w_merged;
        w_merged = old_val;
        for (int b = 0; b < c_MAX_BE; b++) begin
            if (be[b]) begin
                w_merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return w_merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rdport
// Description : One registered read port: range check, optional write
//               bypass with lane merge, and the output data/valid register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 8,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_accept,
    input  logic                    i_rd_en,
    input  logic [AW-1:0]           i_rd_addr,
    input  logic [DEPTH*DATA_W-1:0] i_mem_flat,
    input  logic                    i_wr_en,
    input  logic [AW-1:0]           i_wr_addr,
    input  logic [DATA_W/8-1:0]     i_wr_be,
    input  logic [DATA_W-1:0]       i_wr_data,
    output logic [DATA_W-1:0]       o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_oob
);

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] c_DEPTH_X = (AW+1)'(DEPTH);

    logic              w_in_range;
    logic              w_hit;
    logic [DATA_W-1:0] w_entry;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    assign w_in_range = ({1'b0, i_rd_addr} < c_DEPTH_X);
    // i_wr_en is already qualified by the sequencer being ready.
    assign w_hit      = (BYPASS != 0) && i_wr_en && (i_wr_addr == i_rd_addr);
    assign o_oob      = i_accept && i_rd_en && !w_in_range;

    // Select the addressed entry out of the flattened array.
    always_comb begin
        w_entry = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (i_rd_addr == AW'(e)) begin
                w_entry = i_mem_flat[e*DATA_W +: DATA_W];
            end
        end
    end

    // Out-of-range reads return zero; a colliding write is forwarded lane-wise.
    always_comb begin
        w_next = w_entry;
        if (!w_in_range) begin
            w_next = '0;
        end else if (w_hit) begin
            w_next = DATA_W'(lane_merge(c_MAX_W'(w_entry), c_MAX_W'(i_wr_data),
                                        c_MAX_BE'(i_wr_be)));
        end
    end

    // Output register: data and valid are zero whenever no read was taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (i_accept && i_rd_en) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_next;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-read-port register file with byte-lane
//               writes, registered reads, optional write bypass, a hardware
//               clear sequencer and a sticky out-of-range error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int N_RD   = 2,
    parameter int AW     = 8,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [N_RD-1:0]        rd_en,
    input  logic [N_RD*AW-1:0]     rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic [N_RD-1:0]        rd_valid,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DATA_W/8-1:0]    wr_be,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   busy,
    output logic                   addr_err,
    input  logic                   err_clr
);

    localparam int              c_PW      = $clog2(DEPTH);
    localparam logic [c_PW-1:0] c_LAST    = c_PW'(DEPTH - 1);
    localparam logic [AW:0]     c_DEPTH_X = (AW+1)'(DEPTH);

    state_t                    r_state;
    logic [c_PW-1:0]           r_clr_ptr;
    logic                      r_busy;
    logic                      r_addr_err;
    logic                      w_ready;
    logic                      w_wr_acc;
    logic                      w_wr_oob;
    logic [N_RD-1:0]           w_rd_oob;
    logic [DEPTH*DATA_W-1:0]   w_mem_flat;

    assign w_ready  = (r_state == ST_READY);
    assign w_wr_acc = w_ready && wr_en;
    assign w_wr_oob = w_wr_acc && !({1'b0, wr_addr} < c_DEPTH_X);

    // Clear sequencer: walk every entry once after reset or a clear pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_clr_ptr == c_LAST) begin
                        r_state   <= ST_READY;
                        r_clr_ptr <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear) begin
                        r_state   <= ST_INIT;
                        r_clr_ptr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_clr_ptr <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    // Storage: one register per entry, written by the clear walk or a write.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        logic [DATA_W-1:0] r_entry;
        logic              w_clr_hit;
        logic              w_wr_hit;

        assign w_clr_hit = !w_ready && (r_clr_ptr == c_PW'(e));
        assign w_wr_hit  = w_wr_acc && (wr_addr == AW'(e));

        // Entry update; contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (w_clr_hit) begin
                r_entry <= '0;
            end else if (w_wr_hit) begin
                r_entry <= DATA_W'(lane_merge(c_MAX_W'(r_entry), c_MAX_W'(wr_data),
                                              c_MAX_BE'(wr_be)));
            end
        end

        assign w_mem_flat[e*DATA_W +: DATA_W] = r_entry;
    end

    // Independent read ports.
    for (genvar p = 0; p < N_RD; p++) begin : g_rdport
        regfile_rdport #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rdport (
            .clk        (clk),
            .rst        (rst),
            .i_accept   (w_ready),
            .i_rd_en    (rd_en[p]),
            .i_rd_addr  (rd_addr[p*AW +: AW]),
            .i_mem_flat (w_mem_flat),
            .i_wr_en    (w_wr_acc),
            .i_wr_addr  (wr_addr),
            .i_wr_be    (wr_be),
            .i_wr_data  (wr_data),
            .o_rd_data  (rd_data[p*DATA_W +: DATA_W]),
            .o_rd_valid (rd_valid[p]),
            .o_oob      (w_rd_oob[p])
        );
    end

    // Sticky error flag; a new error beats a simultaneous clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else if (w_wr_oob || (|w_rd_oob)) begin
            r_addr_err <= 1'b1;
        end else if (err_clr) begin
            r_addr_err <= 1'b0;
        end
    end

    assign busy     = r_busy;
    assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Two instances share all
//               inputs (bypass on / bypass off), checked against an
//               array-based reference model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DW = 16;
    localparam int DP = 3;
    localparam int NR = 2;
    localparam int AW = 8;
    localparam int NB = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic            err_clr;
    logic [NR-1:0]   rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [NB-1:0]   wr_be;
    logic [DW-1:0]   wr_data;

    logic [NR*DW-1:0] rd_data_a, rd_data_b;
    logic [NR-1:0]    rd_valid_a, rd_valid_b;
    logic             busy_a, busy_b, err_a, err_b;

    regfile_mp #(.DATA_W(DW), .DEPTH(DP), .N_RD(NR), .AW(AW), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .busy(busy_a), .addr_err(err_a), .err_clr(err_clr)
    );

    regfile_mp #(.DATA_W(DW), .DEPTH(DP), .N_RD(NR), .AW(AW), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data), .busy(busy_b), .addr_err(err_b), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Reference model state and expected outputs.
    logic [DW-1:0]    m [DP];
    int               busy_left;
    logic             exp_err, exp_busy;
    logic [NR-1:0]    exp_v;
    logic [NR*DW-1:0] exp_da, exp_db;
    int               n_cmp = 0;
    int               n_bad = 0;

    function automatic logic [DW-1:0] merge(logic [DW-1:0] o, logic [DW-1:0] n, logic [NB-1:0] be);
        for (int b = 0; b < NB; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    task automatic model_reset();
        busy_left = DP;
        exp_err = 1'b0; exp_busy = 1'b1; exp_v = '0; exp_da = '0; exp_db = '0;
        for (int e = 0; e < DP; e++) m[e] = '0;
    endtask

    task automatic idle();
        clear = 0; err_clr = 0; rd_en = '0; rd_addr = '0;
        wr_en = 0; wr_addr = '0; wr_be = '0; wr_data = '0;
    endtask

    task automatic set_rd(int p, int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(int a, logic [DW-1:0] d, logic [NB-1:0] be);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
    endtask

    // One clock edge; the model advances from the inputs seen at the edge.
    task automatic tick();
        logic set_err;
        int a;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            set_err = 1'b0;
            exp_v = '0; exp_da = '0; exp_db = '0;
            if (busy_left == 0) begin
                for (int p = 0; p < NR; p++) begin
                    if (rd_en[p]) begin
                        a = int'(rd_addr[p*AW +: AW]);
                        exp_v[p] = 1'b1;
                        if (a >= DP) set_err = 1'b1;
                        else begin
                            exp_db[p*DW +: DW] = m[a];
                            exp_da[p*DW +: DW] = (wr_en && int'(wr_addr) == a) ?
                                                 merge(m[a], wr_data, wr_be) : m[a];
                        end
                    end
                end
                if (wr_en) begin
                    if (int'(wr_addr) >= DP) set_err = 1'b1;
                    else m[int'(wr_addr)] = merge(m[int'(wr_addr)], wr_data, wr_be);
                end
                if (clear) begin
                    busy_left = DP;
                    for (int e = 0; e < DP; e++) m[e] = '0;
                end
            end else begin
                busy_left--;
            end
            if (set_err) exp_err = 1'b1;
            else if (err_clr) exp_err = 1'b0;
            exp_busy = (busy_left > 0);
        end
        #1;
    endtask

    task automatic run_busy(output int cyc);
        cyc = 0;
        while (busy_a === 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        idle();
        rst = 1'b1;
        model_reset();
        tick(); tick();
        n_cmp++;
        if ({busy_a, busy_b, err_a, err_b, rd_valid_a, rd_valid_b} !== {4'b1100, 4'b0000} ||
            rd_data_a !== '0 || rd_data_b !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b%b err=%b%b v=%b/%b d=%h/%h, expected busy=11 err=00 v=0 d=0",
                     busy_a, busy_b, err_a, err_b, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b);
        end
        rst = 1'b0;
        set_wr(0, 16'hFFFF, 2'b11);   // must be ignored while clearing
        run_busy(cyc);
        idle();
        n_cmp++;
        if (cyc != DP || busy_b !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy_len: busy cycles=%0d busy_b=%b, expected %0d and 0", cyc, busy_b, DP);
        end
        for (int a = 0; a < DP; a++) begin
            idle(); set_rd(0, a); set_rd(1, a);
            tick();
            n_cmp++;
            if (rd_valid_a !== 2'b11 || rd_data_a !== '0 || rd_valid_b !== 2'b11 || rd_data_b !== '0) begin
                n_bad++;
                $display("FAIL reset_read addr %0d: v=%b/%b d=%h/%h, expected v=11 d=0",
                         a, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        idle(); set_wr(2, 16'h00A5, 2'b11); tick();
        idle(); set_rd(0, 2); set_rd(1, 2); tick();
        n_cmp++;
        if (rd_valid_a !== 2'b11 || rd_data_a !== {16'h00A5, 16'h00A5} || rd_data_b !== {16'h00A5, 16'h00A5}) begin
            n_bad++;
            $display("FAIL write_read: v=%b d=%h/%h, expected v=11 d=00a500a5", rd_valid_a, rd_data_a, rd_data_b);
        end
        idle(); tick();
        n_cmp++;
        if (rd_valid_a !== 2'b00 || rd_data_a !== '0 || rd_valid_b !== 2'b00) begin
            n_bad++;
            $display("FAIL read_idle: v=%b/%b d=%h, expected v=0 d=0", rd_valid_a, rd_valid_b, rd_data_a);
        end
    endtask

    task automatic test_collision();
        idle(); set_wr(1, 16'h003C, 2'b11); tick();
        idle(); set_wr(1, 16'h00F0, 2'b11); set_rd(0, 1); tick();
        n_cmp++;
        if (rd_data_a[15:0] !== 16'h00F0 || rd_data_b[15:0] !== 16'h003C || rd_valid_a !== 2'b01) begin
            n_bad++;
            $display("FAIL collision: bypass=%h nobypass=%h v=%b, expected 00f0 003c v=01",
                     rd_data_a[15:0], rd_data_b[15:0], rd_valid_a);
        end
    endtask

    task automatic test_byte_lane();
        idle(); set_wr(0, 16'h1234, 2'b11); tick();
        idle(); set_wr(0, 16'hABCD, 2'b10); tick();
        idle(); set_wr(0, 16'hFFFF, 2'b00); tick();   // no-op write
        idle(); set_rd(1, 0); tick();
        n_cmp++;
        if (rd_data_a[31:16] !== 16'hAB34 || rd_data_b[31:16] !== 16'hAB34) begin
            n_bad++;
            $display("FAIL byte_lane: got %h/%h, expected ab34", rd_data_a[31:16], rd_data_b[31:16]);
        end
        idle(); set_wr(0, 16'h5566, 2'b01); set_rd(0, 0); tick();
        n_cmp++;
        if (rd_data_a[15:0] !== 16'hAB66 || rd_data_b[15:0] !== 16'hAB34) begin
            n_bad++;
            $display("FAIL lane_bypass: got %h/%h, expected ab66/ab34", rd_data_a[15:0], rd_data_b[15:0]);
        end
        idle();
    endtask

    task automatic test_out_of_range();
        idle(); set_rd(1, DP); tick();
        n_cmp++;
        if (rd_valid_a !== 2'b10 || rd_data_a !== '0 || err_a !== 1'b1 || err_b !== 1'b1) begin
            n_bad++;
            $display("FAIL oob_read: v=%b d=%h err=%b%b, expected v=10 d=0 err=11",
                     rd_valid_a, rd_data_a, err_a, err_b);
        end
        idle(); err_clr = 1'b1; tick();
        idle(); set_wr(DP, 16'hFFFF, 2'b11); tick();
        n_cmp++;
        if (err_a !== 1'b1) begin
            n_bad++;
            $display("FAIL oob_write_err: err=%b, expected 1", err_a);
        end
        for (int a = 0; a < DP; a++) begin
            idle(); set_rd(0, a); set_rd(1, a); tick();
            n_cmp++;
            if (rd_data_a !== exp_da || rd_data_b !== exp_db) begin
                n_bad++;
                $display("FAIL oob_write_array addr %0d: got %h/%h, expected %h/%h",
                         a, rd_data_a, rd_data_b, exp_da, exp_db);
            end
        end
        idle(); err_clr = 1'b1; tick();
        n_cmp++;
        if (err_a !== 1'b0 || err_b !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clr: err=%b%b, expected 00", err_a, err_b);
        end
        idle(); err_clr = 1'b1; set_rd(0, 200); tick();
        n_cmp++;
        if (err_a !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set_wins: err=%b, expected 1", err_a);
        end
        idle(); err_clr = 1'b1; tick(); idle();
    endtask

    task automatic test_clear_restart();
        int cyc;
        idle(); set_wr(1, 16'h7777, 2'b11); set_rd(0, 5); clear = 1'b1; tick();
        n_cmp++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1 || err_a !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_start: busy=%b%b err=%b, expected 11 1", busy_a, busy_b, err_a);
        end
        idle(); set_wr(0, 16'hFFFF, 2'b11); clear = 1'b1;
        run_busy(cyc);
        idle();
        n_cmp++;
        if (cyc != DP) begin
            n_bad++;
            $display("FAIL clear_busy_len: %0d cycles, expected %0d", cyc, DP);
        end
        for (int a = 0; a < DP; a++) begin
            idle(); set_rd(0, a); set_rd(1, a); tick();
            n_cmp++;
            if (rd_valid_a !== 2'b11 || rd_data_a !== '0 || rd_data_b !== '0) begin
                n_bad++;
                $display("FAIL clear_zero addr %0d: v=%b d=%h/%h, expected v=11 d=0",
                         a, rd_valid_a, rd_data_a, rd_data_b);
            end
        end
        // Reset two cycles into a clear sequence.
        idle(); set_wr(2, 16'h1111, 2'b11); tick();
        idle(); clear = 1'b1; tick();
        idle(); set_wr(2, 16'h2222, 2'b11); tick(); tick();
        rst = 1'b1; model_reset(); #1;
        n_cmp++;
        if (busy_a !== 1'b1 || err_a !== 1'b0 || err_b !== 1'b0 || rd_valid_a !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_mid_clear: busy=%b err=%b%b v=%b, expected 1 00 00", busy_a, err_a, err_b, rd_valid_a);
        end
        tick(); rst = 1'b0;
        run_busy(cyc);
        idle();
        n_cmp++;
        if (cyc != DP) begin
            n_bad++;
            $display("FAIL rst_busy_len: %0d cycles, expected %0d", cyc, DP);
        end
        idle(); set_rd(0, 2); set_rd(1, 1); tick();
        n_cmp++;
        if (rd_valid_a !== 2'b11 || rd_data_a !== '0 || rd_data_b !== '0) begin
            n_bad++;
            $display("FAIL rst_clear_zero: v=%b d=%h/%h, expected v=11 d=0", rd_valid_a, rd_data_a, rd_data_b);
        end
        // Reset in the middle of a read.
        idle(); set_rd(0, 2); set_rd(1, 0); tick();
        rst = 1'b1; model_reset(); #1;
        n_cmp++;
        if (rd_valid_a !== 2'b00 || rd_valid_b !== 2'b00 || rd_data_a !== '0 || busy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_read: v=%b/%b d=%h busy=%b, expected v=0 d=0 busy=1",
                     rd_valid_a, rd_valid_b, rd_data_a, busy_a);
        end
        idle(); tick(); rst = 1'b0;
        run_busy(cyc);
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear   = ($urandom_range(0, 39) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, DP - 1));
            wr_be   = NB'($urandom);
            wr_data = DW'($urandom);
            for (int p = 0; p < NR; p++) begin
                rd_en[p] = ($urandom_range(0, 2) != 0);
                rd_addr[p*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, DP - 1));
            end
            tick();
            n_cmp++;
            if (busy_a !== exp_busy || busy_b !== exp_busy || err_a !== exp_err || err_b !== exp_err ||
                rd_valid_a !== exp_v || rd_valid_b !== exp_v || rd_data_a !== exp_da || rd_data_b !== exp_db) begin
                n_bad++;
                $display("FAIL random cyc %0d: busy=%b%b err=%b%b v=%b/%b d=%h/%h, expected busy=%b err=%b v=%b d=%h/%h",
                         c, busy_a, busy_b, err_a, err_b, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b,
                         exp_busy, exp_err, exp_v, exp_da, exp_db);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_byte_lane();
        test_out_of_range();
        test_clear_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
